// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the multicycle controller.
// It holds the program counter (PC) and the instruction register (INSTR),
// fetches from instruction memory over a req/ack handshake, and computes
// the next PC from the controller's select lines.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_f      synchronous active-low reset
//   pc_write   PC update request; acts only on its rising edge
//   pc_sel     0 = PC+1, 1 = branch target
//   br_sel     0 = absolute branch, 1 = PC-relative branch
//   pc_rst     force the next PC to 0; overrides pc_sel
//   im_ack     instruction memory data valid
//   im_data    instruction word, sampled while im_ack = 1
//   im_req     fetch request
//   im_addr    fetch address; always equal to pc
//   pc         current program counter
//   instr      instruction register
//   opcode     instr[31:28]
//   mm         instr[27:24]
//   ir_valid   instr holds the word fetched from pc
//   fetch_busy same as im_req
//   halted     a HLT (opcode 4'hF) was fetched; fetch is frozen
//
// state | meaning
// IDLE  | one cycle after reset release, no fetch yet
// REQ   | request outstanding at im_addr = pc, waiting for im_ack
// HOLD  | instr valid, waiting for a pc_write rise or applying a pending one
// HALT  | HLT fetched, everything frozen until reset

module fetch_unit #(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            pc_write,
  input  logic            pc_sel,
  input  logic            br_sel,
  input  logic            pc_rst,
  input  logic            im_ack,
  input  logic [31:0]     im_data,
  output logic            im_req,
  output logic [PC_W-1:0] im_addr,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     instr,
  output logic [3:0]      opcode,
  output logic [3:0]      mm,
  output logic            ir_valid,
  output logic            fetch_busy,
  output logic            halted
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;

  state_t          state;
  state_t          state_nx;
  logic            pw_q;
  logic            pw_rise;
  logic            pending;
  logic            p_sel;
  logic            p_br;
  logic            p_rst;
  logic            use_sel;
  logic            use_br;
  logic            use_rst;
  logic            ack_hlt;
  logic [PC_W-1:0] rel_off;
  logic [PC_W-1:0] next_pc;

  assign pw_rise = pc_write & ~pw_q;
  assign ack_hlt = (im_data[31:28] == 4'hF);

  // A pending update (captured while a fetch was in flight) takes precedence
  // over the live select lines in the HOLD cycle that follows the ack.
  assign use_sel = pending ? p_sel : pc_sel;
  assign use_br  = pending ? p_br  : br_sel;
  assign use_rst = pending ? p_rst : pc_rst;

  // Sign-extended 16-bit offset, truncated to the PC width; the add then
  // wraps naturally in either direction.
  assign rel_off = PC_W'({{16{instr[15]}}, instr[15:0]});

  always_comb begin
    if (use_rst) begin
      next_pc = '0;
    end else if (!use_sel) begin
      next_pc = pc + {{(PC_W-1){1'b0}}, 1'b1};
    end else if (!use_br) begin
      next_pc = instr[PC_W-1:0];
    end else begin
      next_pc = pc + rel_off;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = REQ;
      REQ: begin
        if (im_ack) begin
          state_nx = ack_hlt ? HALT : HOLD;
        end
      end
      HOLD: begin
        if (pending || pw_rise) begin
          state_nx = REQ;
        end
      end
      HALT: state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    im_req = (state == REQ);
    halted = (state == HALT);
  end

  assign fetch_busy = im_req;
  assign im_addr    = pc;
  assign opcode     = instr[31:28];
  assign mm         = instr[27:24];

  // Datapath: PC, instruction register and the pending-update capture
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      pc       <= '0;
      instr    <= '0;
      ir_valid <= 1'b0;
      pending  <= 1'b0;
      pw_q     <= 1'b0;
      p_sel    <= 1'b0;
      p_br     <= 1'b0;
      p_rst    <= 1'b0;
    end else begin
      pw_q <= pc_write;
      case (state)
        REQ: begin
          // A later rise in the same fetch simply overwrites the capture.
          if (pw_rise) begin
            pending <= 1'b1;
            p_sel   <= pc_sel;
            p_br    <= br_sel;
            p_rst   <= pc_rst;
          end
          if (im_ack) begin
            instr    <= im_data;
            ir_valid <= 1'b1;
            // A HLT word discards any update queued during its own fetch.
            if (ack_hlt) begin
              pending <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (pending || pw_rise) begin
            pc       <= next_pc;
            ir_valid <= 1'b0;
            pending  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A behavioural instruction memory with
// a programmable wait count answers requests; every expected fetch
// (address + word) is pushed to a scoreboard queue when the PC update that
// causes it is driven, and popped when IR_VALID rises.

module tb_fetch_unit;

  localparam int PC_W = 16;

  logic            clk = 1'b0;
  logic            rst_f;
  logic            pc_write;
  logic            pc_sel;
  logic            br_sel;
  logic            pc_rst;
  logic            im_ack;
  logic [31:0]     im_data;
  logic            im_req;
  logic [PC_W-1:0] im_addr;
  logic [PC_W-1:0] pc;
  logic [31:0]     instr;
  logic [3:0]      opcode;
  logic [3:0]      mm;
  logic            ir_valid;
  logic            fetch_busy;
  logic            halted;

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(PC_W)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .br_sel     (br_sel),
    .pc_rst     (pc_rst),
    .im_ack     (im_ack),
    .im_data    (im_data),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .pc         (pc),
    .instr      (instr),
    .opcode     (opcode),
    .mm         (mm),
    .ir_valid   (ir_valid),
    .fetch_busy (fetch_busy),
    .halted     (halted)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction memory model
  logic [31:0] mem [0:65535];
  int          waits;
  int          cnt = 0;
  logic        mem_ack = 1'b0;
  logic        extra_ack;
  logic [31:0] extra_data;

  assign im_ack  = mem_ack | extra_ack;
  assign im_data = extra_ack ? extra_data : mem[im_addr];

  always @(negedge clk) begin
    if (!im_req) begin
      mem_ack <= 1'b0;
      cnt     <= 0;
    end else if (!mem_ack) begin
      if (cnt >= waits) mem_ack <= 1'b1;
      else cnt <= cnt + 1;
    end
  end

  // Scoreboard and reference next-PC model
  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } fetch_t;

  fetch_t      sb[$];
  logic [15:0] m_pc;
  logic [31:0] m_instr;

  function automatic logic [15:0] ref_next(input logic [15:0] p, input logic [31:0] ins,
                                           input logic s, input logic b, input logic r);
    if (r) return 16'h0000;
    if (!s) return p + 16'd1;
    if (!b) return ins[15:0];
    return p + ins[15:0];
  endfunction

  task automatic push_exp(input logic [15:0] a);
    fetch_t e;
    m_pc    = a;
    m_instr = mem[a];
    e.addr  = a;
    e.data  = m_instr;
    sb.push_back(e);
  endtask

  // Drive a PC_WRITE level for cyc cycles and queue the fetch it implies.
  task automatic issue(input logic s, input logic b, input logic r, input int cyc);
    push_exp(ref_next(m_pc, m_instr, s, b, r));
    pc_sel   = s;
    br_sel   = b;
    pc_rst   = r;
    pc_write = 1'b1;
    repeat (cyc) @(negedge clk);
    pc_write = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!ir_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!ir_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: address stability, request counting, scoreboard pop
  logic        req_q   = 1'b0;
  logic        valid_q = 1'b0;
  logic [15:0] held    = '0;
  int          req_count = 0;

  always @(negedge clk) begin
    check("busy_eq_req", 32'(fetch_busy), 32'(im_req));
    if (im_req) begin
      check("addr_eq_pc", 32'(im_addr), 32'(pc));
      if (!req_q) begin
        held      <= im_addr;
        req_count <= req_count + 1;
      end else begin
        check("addr_stable", 32'(im_addr), 32'(held));
      end
    end
    if (ir_valid && !valid_q) begin
      if (sb.size() == 0) begin
        check("unexpected_fetch", 32'd1, 32'd0);
      end else begin
        fetch_t e;
        e = sb.pop_front();
        check("fetch_addr", 32'(pc), 32'(e.addr));
        check("fetch_instr", instr, e.data);
      end
    end
    req_q   <= im_req;
    valid_q <= ir_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    for (int i = 0; i < 65536; i++) mem[i] = 32'h1000_0000;
    mem[16'h0000] = 32'h8000_0000;
    mem[16'h0001] = 32'h4000_0005;
    mem[16'h0002] = 32'h7000_FFF0;
    mem[16'h0004] = 32'h4000_0030;
    mem[16'h0006] = 32'h4000_0010;
    mem[16'h0010] = 32'h6000_FFFD;
    mem[16'h000D] = 32'h4000_0123;
    mem[16'h0123] = 32'h4000_FFFF;
    mem[16'h0030] = 32'hF000_0000;

    rst_f = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0; pc_rst = 1'b0;
    extra_ack = 1'b0; extra_data = 32'h0; waits = 0;
    repeat (2) @(negedge clk);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_valid", 32'(ir_valid), 32'd0);
    check("rst_req", 32'(im_req), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    // Release: IDLE, then request at 0, valid on the third edge counting the last reset edge
    push_exp(16'h0000);
    rst_f = 1'b1;
    @(negedge clk);
    check("first_req", 32'(im_req), 32'd1);
    check("first_addr", 32'(im_addr), 32'd0);
    check("first_valid_early", 32'(ir_valid), 32'd0);
    @(negedge clk);
    check("first_valid", 32'(ir_valid), 32'd1);
    check("first_opcode", 32'(opcode), 32'd8);
    check("first_mm", 32'(mm), 32'd0);

    // Ack outside REQ is ignored
    extra_data = 32'h2222_2222;
    extra_ack  = 1'b1;
    @(negedge clk);
    extra_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_instr", instr, 32'h8000_0000);
    check("stray_ack_req", 32'(im_req), 32'd0);

    issue(1'b0, 1'b0, 1'b0, 1); wait_valid(20);
    issue(1'b1, 1'b0, 1'b0, 1); wait_valid(20);
    check("abs_pc5", 32'(pc), 32'h5);

    // Level held high for 4 cycles: exactly one update
    rc = req_count;
    issue(1'b0, 1'b0, 1'b0, 4); wait_valid(20);
    repeat (3) @(negedge clk);
    check("held_one_req", 32'(req_count - rc), 32'd1);
    check("held_pc", 32'(pc), 32'h6);

    issue(1'b1, 1'b0, 1'b0, 1); wait_valid(20);
    issue(1'b1, 1'b1, 1'b0, 1); wait_valid(20);
    check("rel_back", 32'(pc), 32'h000D);
    issue(1'b1, 1'b0, 1'b0, 1); wait_valid(20);
    check("abs_123", 32'(pc), 32'h0123);
    issue(1'b1, 1'b0, 1'b0, 1); wait_valid(20);
    check("abs_ffff", 32'(pc), 32'hFFFF);
    issue(1'b0, 1'b0, 1'b0, 1); wait_valid(20);
    check("inc_wrap", 32'(pc), 32'h0000);
    issue(1'b0, 1'b0, 1'b0, 1); wait_valid(20);
    issue(1'b0, 1'b0, 1'b0, 1); wait_valid(20);
    issue(1'b1, 1'b1, 1'b0, 1); wait_valid(20);
    check("rel_wrap", 32'(pc), 32'hFFF2);
    issue(1'b1, 1'b1, 1'b1, 1); wait_valid(20);
    check("pc_rst_wins", 32'(pc), 32'h0000);

    // 3 wait cycles, rise during REQ -> pending sequential update
    waits = 3;
    issue(1'b0, 1'b0, 1'b0, 1);
    @(negedge clk);
    issue(1'b0, 1'b0, 1'b0, 1);
    wait_valid(20);
    check("pend_ack_req", 32'(im_req), 32'd0);
    check("pend_ack_instr", instr, 32'h4000_0005);
    @(negedge clk);
    check("pend_req", 32'(im_req), 32'd1);
    check("pend_addr", 32'(im_addr), 32'h2);
    check("pend_valid", 32'(ir_valid), 32'd0);
    wait_valid(20);

    // Two rises in one REQ: the second overwrites the first (pc_rst dropped)
    waits = 5;
    issue(1'b0, 1'b0, 1'b0, 1);
    @(negedge clk);
    pc_write = 1'b1; pc_rst = 1'b1; pc_sel = 1'b1;
    @(negedge clk);
    pc_write = 1'b0;
    @(negedge clk);
    issue(1'b0, 1'b0, 1'b0, 1);
    wait_valid(20);
    @(negedge clk);
    wait_valid(20);
    check("overwrite_pc", 32'(pc), 32'h4);

    // HLT fetch with an update queued during it: update discarded
    waits = 2;
    issue(1'b1, 1'b0, 1'b0, 1);
    @(negedge clk);
    pc_write = 1'b1; pc_sel = 1'b0; pc_rst = 1'b0;
    @(negedge clk);
    pc_write = 1'b0;
    wait_valid(20);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_opcode", 32'(opcode), 32'hF);
    check("halt_pc", 32'(pc), 32'h30);
    rc = req_count;
    for (int k = 0; k < 3; k++) begin
      pc_write = 1'b1;
      @(negedge clk);
      pc_write = 1'b0;
      @(negedge clk);
    end
    extra_ack = 1'b1;
    @(negedge clk);
    extra_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("halt_frozen_pc", 32'(pc), 32'h30);
    check("halt_no_req", 32'(req_count - rc), 32'd0);
    check("halt_stays", 32'(halted), 32'd1);
    check("halt_valid", 32'(ir_valid), 32'd1);
    check("halt_instr", instr, 32'hF000_0000);

    // Reset leaves HALT
    rst_f = 1'b0;
    @(negedge clk);
    check("rst2_halted", 32'(halted), 32'd0);
    check("rst2_pc", 32'(pc), 32'd0);
    sb.delete();
    waits = 10;
    rst_f = 1'b1;
    @(negedge clk);
    check("mid_req", 32'(im_req), 32'd1);

    // Reset and ack on the same edge: reset wins, data dropped
    rst_f      = 1'b0;
    extra_data = 32'h2222_2222;
    extra_ack  = 1'b1;
    @(negedge clk);
    extra_ack = 1'b0;
    check("rst_ack_pc", 32'(pc), 32'd0);
    check("rst_ack_instr", instr, 32'd0);
    check("rst_ack_valid", 32'(ir_valid), 32'd0);
    check("rst_ack_req", 32'(im_req), 32'd0);
    check("rst_ack_halted", 32'(halted), 32'd0);
    check("rst_ack_opcode", 32'(opcode), 32'd0);

    waits = 0;
    push_exp(16'h0000);
    rst_f = 1'b1;
    @(negedge clk);
    wait_valid(20);
    @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly upstream of the multicycle control FSM. Owns the program counter and instruction register, issues requests to instruction memory over a req/ack handshake, and presents OPCODE/MM to the controller. Consumes the controller's PC_WRITE, PC_SEL, BR_SEL and PC_RST to compute the next PC: sequential, absolute branch, relative branch or reset.

## Interface
- PC_W, 16, program-counter width in words (8..16)
- CLK  in  1  clock, all state updates on rising edge
- RST_F  in  1  synchronous, active-low reset
- PC_WRITE  in  1  PC update request from controller (rising-edge qualified)
- PC_SEL  in  1  0 = PC+1, 1 = branch target
- BR_SEL  in  1  branch type: 0 = absolute, 1 = PC-relative
- PC_RST  in  1  force next PC to 0 (overrides PC_SEL)
- IM_ACK  in  1  instruction memory data valid
- IM_DATA  in  32  instruction word, sampled when IM_ACK=1
- IM_REQ  out  1  fetch request
- IM_ADDR  out  PC_W  fetch address, equal to PC
- PC  out  PC_W  current program counter
- INSTR  out  32  instruction register
- OPCODE  out  4  INSTR[31:28], combinational from IR
- MM  out  4  INSTR[27:24], combinational from IR
- IR_VALID  out  1  INSTR holds the word fetched from PC
- FETCH_BUSY  out  1  equal to IM_REQ; controller must not expect new OPCODE
- HALTED  out  1  captured OPCODE = 4'hF; fetch frozen

## Operation
- States: IDLE, REQ, HOLD, HALT.
- Reset (RST_F=0 at an edge): PC=0, INSTR=0, IR_VALID=0, IM_REQ=0, HALTED=0, pending=0, pw_q=0, state=IDLE. RST_F has priority over every other input, mid-request included.
- IDLE: one cycle after reset release, go to REQ with PC=0. No PC update occurs.
- REQ: IM_REQ=1, IM_ADDR=PC, both stable until ack. On IM_ACK=1: INSTR<=IM_DATA, IR_VALID<=1, IM_REQ<=0. Go to HALT if IM_DATA[31:28]=4'hF, else go to HOLD.
- HOLD: on PC_WRITE rise (PC_WRITE=1 and pw_q=0), PC<=next_pc, IR_VALID<=0, go to REQ.
- HALT: HALTED=1; PC_WRITE, IM_ACK ignored; exit only by reset.
- pw_q is a registered copy of PC_WRITE. A level held high produces exactly one update.
- next_pc: if PC_RST then 0. Else if PC_SEL=0 then PC+1. Else if BR_SEL=0 then INSTR[PC_W-1:0]. Else PC + sext(INSTR[15:0]) truncated to PC_W.
- All PC arithmetic is modulo 2^PC_W. PC+1 at all-ones wraps to 0. Relative target wraps in either direction.
- Relative base is the PC of the instruction currently in INSTR.
- PC_WRITE rise during REQ: set pending and capture PC_SEL/BR_SEL/PC_RST. On ack, INSTR loads as normal and the state goes to HOLD. In that HOLD cycle, apply the captured selects against the new INSTR, then clear pending and go to REQ. Only one pending update is held; a second rise during the same REQ overwrites the captured selects.
- A pending update is discarded if the acked word is HLT.
- IM_ACK outside REQ is ignored; INSTR is unchanged.

## Timing
- Edge t samples a PC_WRITE rise in HOLD. At t+1, PC is new, IM_REQ=1 and IR_VALID=0.
- IM_ACK sampled high at edge t+1+k (k≥0 wait cycles) loads INSTR. IR_VALID=1 and IM_REQ=0 after that edge.
- Minimum PC_WRITE-rise to IR_VALID: 2 edges. Reset release to first IR_VALID: 3 edges with zero-wait memory.
- A pending update issues its new request 1 cycle after the ack (the HOLD cycle), with no extra bubble.
- OPCODE and MM change only on the edge that loads INSTR.
- Simultaneous PC_RST and PC_SEL: PC_RST wins. Simultaneous RST_F=0 and IM_ACK: reset wins and the data is dropped.

## Test plan
- Reset, zero-wait memory returning 0x8000_0000 at address 0 → IM_ADDR=0 first request; IR_VALID=1 on 3rd edge after release; OPCODE=8.
- HOLD with PC=5, PC_WRITE held high 4 cycles, PC_SEL=0 → exactly one update; PC=6; one request.
- INSTR=0x6000_FFFD at PC=0x0010, PC_SEL=1, BR_SEL=1 → PC=0x000D. Then INSTR=0x4000_0123 with BR_SEL=0 → PC=0x0123.
- PC=0xFFFF, PC_SEL=0 → PC=0x0000. PC=0x0002 with offset 0xFFF0 → PC=0xFFF2.
- Memory with 3 wait cycles, PC_WRITE rise during REQ with PC_SEL=0 → INSTR loads, the next request at PC+1 is issued 1 cycle after the ack, and IM_ADDR is stable through each wait period.
- Ack of 0xF000_0000 → HALTED=1, later PC_WRITE pulses are ignored. Then RST_F low for 1 edge while in REQ with an ack at the same edge → all outputs at reset values and INSTR=0.
